fetch_sequencer: RTL

- Multi-cycle control FSM that sequences the processor datapath: drives the PC into the instruction memory, latches the returned 8-bit InstructionCode, decodes it, and issues register-file/ALU controls.
- Replaces the free-running PC increment with a controlled fetch/decode/execute loop that supports jumps, halt and memory wait states.
- Sits between instruction memory and the register file/ALU.

---
 rtl/fetch_seq_pkg.sv | 19 +
 rtl/fetch_sequencer_instr_decoder.sv | 30 +++
 rtl/fetch_sequencer.sv | 96 +++++++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared state/opcode encodings and widths for the fetch sequencer
package fetch_seq_pkg;
  localparam int INSTR_W = 8;
  localparam int PC_W_DEFAULT = 8;
  localparam logic [INSTR_W-1:0] HALT_CODE = 8'hFF;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_ADD = 2'b01,
    OP_JMP = 2'b10,
    OP_SYS = 2'b11
  } opcode_t;
endpackage

// File: rtl/fetch_sequencer_instr_decoder.sv
// instr_decoder: combinational IR decode into register fields, ALU op and control flags
//   ir_i        instruction register
//   read_reg_o  source register IR[2:0];  write_reg_o  destination IR[5:3]
//   alu_op_o    1 = add rd+rs;  is_write_o / is_jump_o / is_halt_o  class flags
//   jmp_off_o   IR[5:0] sign-extended to PC_WIDTH
module instr_decoder
  import fetch_seq_pkg::*;
#(
  parameter int PC_WIDTH   = PC_W_DEFAULT,
  parameter int REG_ADDR_W = 3
) (
  input  logic [INSTR_W-1:0]    ir_i,
  output logic [REG_ADDR_W-1:0] read_reg_o,
  output logic [REG_ADDR_W-1:0] write_reg_o,
  output logic                  alu_op_o,
  output logic                  is_write_o,
  output logic                  is_jump_o,
  output logic                  is_halt_o,
  output logic [PC_WIDTH-1:0]   jmp_off_o
);
  opcode_t op;
  assign op          = opcode_t'(ir_i[7:6]);
  assign read_reg_o  = ir_i[REG_ADDR_W-1:0];
  assign write_reg_o = ir_i[2*REG_ADDR_W-1:REG_ADDR_W];
  assign alu_op_o    = op == OP_ADD;
  assign is_write_o  = op == OP_MOV || op == OP_ADD;
  assign is_jump_o   = op == OP_JMP;
  assign is_halt_o   = ir_i == HALT_CODE;
  assign jmp_off_o   = {{(PC_WIDTH-6){ir_i[5]}}, ir_i[5:0]};
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/decode/execute control FSM with jump, halt and memory wait states
//   clk, Reset (async, active-low), run (start, sampled in IDLE)
//   imem_ready / InstructionCode  instruction memory handshake and data
//   PC, IR                        registered program counter and instruction register
//   ReadReg, WriteReg, AluOp      register-file/ALU controls decoded from IR
//   RegWrite, InstrDone           one-cycle strobes in EXEC
//   Busy, Halted                  status
//   retire_count                  only with SEQ_RETIRE_COUNT_EN: saturating count of retired instructions
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int                  PC_WIDTH     = PC_W_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  REG_ADDR_W   = 3
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  run,
  input  logic                  imem_ready,
  input  logic [INSTR_W-1:0]    InstructionCode,
  output logic [PC_WIDTH-1:0]   PC,
  output logic [INSTR_W-1:0]    IR,
  output logic [REG_ADDR_W-1:0] ReadReg,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic                  AluOp,
  output logic                  RegWrite,
  output logic                  InstrDone,
  output logic                  Busy,
  output logic                  Halted
`ifdef SEQ_RETIRE_COUNT_EN
  ,
  output logic [15:0]           retire_count
`endif
);
  state_t state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, jmp_off;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic alu_op, is_write, is_jump, is_halt, in_exec;
  instr_decoder #(.PC_WIDTH(PC_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_dec (
    .ir_i       (ir_q),
    .read_reg_o (ReadReg),
    .write_reg_o(WriteReg),
    .alu_op_o   (alu_op),
    .is_write_o (is_write),
    .is_jump_o  (is_jump),
    .is_halt_o  (is_halt),
    .jmp_off_o  (jmp_off)
  );
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        ir_d    = imem_ready ? InstructionCode : ir_q;
        state_d = imem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        // HALT leaves PC pointing at itself; everything else advances or jumps
        state_d = is_halt ? S_HALTED : S_FETCH;
        pc_d    = is_halt ? pc_q : pc_q + (is_jump ? jmp_off : PC_WIDTH'(1));
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end
  assign in_exec   = state_q == S_EXEC;
  assign PC        = pc_q;
  assign IR        = ir_q;
  assign RegWrite  = in_exec && is_write;
  assign InstrDone = in_exec;
  assign AluOp     = (in_exec || state_q == S_DECODE) && alu_op;
  assign Busy      = state_q == S_FETCH || state_q == S_DECODE || in_exec;
  assign Halted    = state_q == S_HALTED;
`ifdef SEQ_RETIRE_COUNT_EN
  logic [15:0] rc_q;
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) rc_q <= '0;
    else if (InstrDone && rc_q != 16'hFFFF) rc_q <= rc_q + 16'd1;
  end
  assign retire_count = rc_q;
`endif
endmodule
